// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Writeback stage of the BURAQ RV32I core. It writes non-load
//                results one cycle after acceptance. For loads it waits a
//                bounded number of cycles for the data-memory response, then
//                aligns and sign/zero-extends the loaded data before writing
//                it. It also counts retired instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_stage #(
    parameter int DataWidth    = 32,
    parameter int AddrRegWidth = 5,
    parameter int LoadTimeout  = 16
) (
    input  logic                    brq_clk,
    input  logic                    brq_rst,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [AddrRegWidth-1:0] mem_rd,
    input  logic                    mem_rd_we,
    input  logic                    mem_is_load,
    input  logic [2:0]              mem_funct3,
    input  logic [1:0]              mem_addr_lsb,
    input  logic [DataWidth-1:0]    mem_result,
    input  logic                    dmem_rvalid,
    input  logic [DataWidth-1:0]    dmem_rdata,
    output logic                    rf_we,
    output logic [AddrRegWidth-1:0] rf_waddr,
    output logic [DataWidth-1:0]    rf_wdata,
    output logic                    load_err,
    output logic [31:0]             retire_cnt
);

    localparam int c_CNT_W = (LoadTimeout > 2) ? $clog2(LoadTimeout) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LoadTimeout - 1);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_t;

    state_t                  r_state, w_state_n;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_n;
    logic [AddrRegWidth-1:0] r_rd, w_rd_n;
    logic                    r_rd_we, w_rd_we_n;
    logic [2:0]              r_funct3, w_funct3_n;
    logic [1:0]              r_lsb, w_lsb_n;

    logic                    r_rf_we, w_rf_we_n;
    logic [AddrRegWidth-1:0] r_rf_waddr, w_rf_waddr_n;
    logic [DataWidth-1:0]    r_rf_wdata, w_rf_wdata_n;
    logic                    r_load_err, w_load_err_n;
    logic [31:0]             r_retire_cnt;
    logic                    w_retire;

    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DataWidth-1:0]    w_ext;

    // Select and extend the loaded data according to the captured load type.
    always_comb begin
        w_byte = dmem_rdata[{r_lsb, 3'b000} +: 8];
        w_half = dmem_rdata[{r_lsb[1], 4'b0000} +: 16];
        w_ext  = dmem_rdata;
        case (r_funct3)
            3'b000:  w_ext = {{(DataWidth-8){w_byte[7]}}, w_byte};
            3'b100:  w_ext = {{(DataWidth-8){1'b0}}, w_byte};
            3'b001:  w_ext = {{(DataWidth-16){w_half[15]}}, w_half};
            3'b101:  w_ext = {{(DataWidth-16){1'b0}}, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    // Next-state, capture and writeback decisions for the two-state control.
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_rd_n       = r_rd;
        w_rd_we_n    = r_rd_we;
        w_funct3_n   = r_funct3;
        w_lsb_n      = r_lsb;
        w_rf_we_n    = 1'b0;
        w_rf_waddr_n = r_rf_waddr;
        w_rf_wdata_n = r_rf_wdata;
        w_load_err_n = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (mem_is_load) begin
                        w_rd_n     = mem_rd;
                        w_rd_we_n  = mem_rd_we;
                        w_funct3_n = mem_funct3;
                        w_lsb_n    = mem_addr_lsb;
                        w_cnt_n    = '0;
                        w_state_n  = ST_LOAD_WAIT;
                    end else begin
                        w_retire  = 1'b1;
                        w_rf_we_n = mem_rd_we && (mem_rd != '0);
                        // Address/data only move on a real write; x0 writes leave them untouched.
                        if (w_rf_we_n) begin
                            w_rf_waddr_n = mem_rd;
                            w_rf_wdata_n = mem_result;
                        end
                    end
                end
            end
            ST_LOAD_WAIT: begin
                // A response in the final wait cycle still wins over the timeout.
                if (dmem_rvalid) begin
                    w_retire  = 1'b1;
                    w_rf_we_n = r_rd_we && (r_rd != '0);
                    if (w_rf_we_n) begin
                        w_rf_waddr_n = r_rd;
                        w_rf_wdata_n = w_ext;
                    end
                    w_state_n = ST_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_load_err_n = 1'b1;
                    w_state_n    = ST_IDLE;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // State, captured load fields and registered outputs; reset dominates.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_rd         <= '0;
            r_rd_we      <= 1'b0;
            r_funct3     <= '0;
            r_lsb        <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_load_err   <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_rd       <= w_rd_n;
            r_rd_we    <= w_rd_we_n;
            r_funct3   <= w_funct3_n;
            r_lsb      <= w_lsb_n;
            r_rf_we    <= w_rf_we_n;
            r_rf_waddr <= w_rf_waddr_n;
            r_rf_wdata <= w_rf_wdata_n;
            r_load_err <= w_load_err_n;
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign mem_ready  = (r_state == ST_IDLE);
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign load_err   = r_load_err;
    assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage. The driver schedules the
//                expected outcome of every transaction by edge number; one
//                compare process checks all outputs on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_stage;

    localparam int c_LT = 16;

    logic        brq_clk = 1'b0;
    logic        brq_rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic        mem_rd_we;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lsb;
    logic [31:0] mem_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        load_err;
    logic [31:0] retire_cnt;

    wb_stage #(.DataWidth(32), .AddrRegWidth(5), .LoadTimeout(c_LT)) u_dut (
        .brq_clk      (brq_clk),
        .brq_rst      (brq_rst),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_rd_we    (mem_rd_we),
        .mem_is_load  (mem_is_load),
        .mem_funct3   (mem_funct3),
        .mem_addr_lsb (mem_addr_lsb),
        .mem_result   (mem_result),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .load_err     (load_err),
        .retire_cnt   (retire_cnt)
    );

    always #5 brq_clk = ~brq_clk;

    int cyc = 0;
    always @(posedge brq_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Expected events, keyed by the number of the edge that produces them.
    bit          ev_rst  [int];
    bit          ev_we   [int];
    logic [4:0]  ev_addr [int];
    logic [31:0] ev_data [int];
    bit          ev_ret  [int];
    bit          ev_err  [int];
    bit          busy    [int];

    bit          en = 1'b0;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_cnt;
    bit          e_we, e_err, e_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [2:0] f, input logic [1:0] lsb, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * lsb)) & 32'hFF;
        h = (d >> (16 * lsb[1])) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    // Compare every output against the scheduled model on each falling edge.
    always @(negedge brq_clk) begin
        if (ev_rst.exists(cyc)) begin
            en     = 1'b1;
            m_addr = '0;
            m_data = '0;
            m_cnt  = '0;
        end
        if (en) begin
            e_we  = ev_we.exists(cyc) ? ev_we[cyc] : 1'b0;
            e_err = ev_err.exists(cyc) ? ev_err[cyc] : 1'b0;
            e_rdy = !busy.exists(cyc);
            if (e_we) begin
                m_addr = ev_addr[cyc];
                m_data = ev_data[cyc];
            end
            if (ev_ret.exists(cyc)) m_cnt = m_cnt + 32'd1;
            chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
            chk("load_err", {31'd0, load_err}, {31'd0, e_err});
            chk("mem_ready", {31'd0, mem_ready}, {31'd0, e_rdy});
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_addr});
            chk("rf_wdata", rf_wdata, m_data);
            chk("retire_cnt", retire_cnt, m_cnt);
        end
    end

    task automatic tick();
        @(posedge brq_clk);
        #1;
    endtask

    task automatic do_reset();
        brq_rst = 1'b1;
        ev_rst[cyc + 1] = 1'b1;
        tick();
        brq_rst = 1'b0;
    endtask

    task automatic do_alu(input logic [4:0] rd, input bit we, input logic [31:0] res);
        mem_valid   = 1'b1;
        mem_is_load = 1'b0;
        mem_rd      = rd;
        mem_rd_we   = we;
        mem_result  = res;
        mem_funct3  = 3'($urandom);
        ev_ret[cyc + 1] = 1'b1;
        if (we && rd != 0) begin
            ev_we[cyc + 1]   = 1'b1;
            ev_addr[cyc + 1] = rd;
            ev_data[cyc + 1] = res;
        end
        tick();
        mem_valid = 1'b0;
    endtask

    // d < c_LT: response after d empty wait cycles; d >= c_LT: no response.
    task automatic do_load(input logic [4:0] rd, input bit we, input logic [2:0] f3,
                           input logic [1:0] lsb, input int d, input logic [31:0] data);
        mem_valid    = 1'b1;
        mem_is_load  = 1'b1;
        mem_rd       = rd;
        mem_rd_we    = we;
        mem_funct3   = f3;
        mem_addr_lsb = lsb;
        mem_result   = $urandom;
        tick();
        mem_valid = 1'b0;
        if (d < c_LT) begin
            for (int j = 0; j < d; j++) begin
                busy[cyc] = 1'b1;
                tick();
            end
            busy[cyc]   = 1'b1;
            dmem_rvalid = 1'b1;
            dmem_rdata  = data;
            ev_ret[cyc + 1] = 1'b1;
            if (we && rd != 0) begin
                ev_we[cyc + 1]   = 1'b1;
                ev_addr[cyc + 1] = rd;
                ev_data[cyc + 1] = ext(f3, lsb, data);
            end
            tick();
            dmem_rvalid = 1'b0;
        end else begin
            for (int j = 0; j < c_LT; j++) begin
                busy[cyc] = 1'b1;
                if (j == c_LT - 1) ev_err[cyc + 1] = 1'b1;
                tick();
            end
        end
    endtask

    task automatic do_idle(input bit rv);
        mem_valid   = 1'b0;
        dmem_rvalid = rv;
        dmem_rdata  = $urandom;
        tick();
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        brq_rst = 1'b0; mem_valid = 1'b0; mem_rd = '0; mem_rd_we = 1'b0;
        mem_is_load = 1'b0; mem_funct3 = '0; mem_addr_lsb = '0; mem_result = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;

        do_reset();
        @(negedge brq_clk);
        chk("lit_rst_we", {31'd0, rf_we}, 32'd0);
        chk("lit_rst_wdata", rf_wdata, 32'd0);
        chk("lit_rst_cnt", retire_cnt, 32'd0);
        chk("lit_rst_ready", {31'd0, mem_ready}, 32'd1);

        do_alu(5'd5, 1'b1, 32'hDEADBEEF);
        @(negedge brq_clk);
        chk("lit_alu_we", {31'd0, rf_we}, 32'd1);
        chk("lit_alu_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("lit_alu_wdata", rf_wdata, 32'hDEADBEEF);
        chk("lit_alu_cnt", retire_cnt, 32'd1);

        do_alu(5'd0, 1'b1, 32'h11111111);
        @(negedge brq_clk);
        chk("lit_x0_we", {31'd0, rf_we}, 32'd0);
        chk("lit_x0_cnt", retire_cnt, 32'd2);

        do_load(5'd7, 1'b1, 3'b000, 2'd2, 3, 32'h12F45678);
        @(negedge brq_clk);
        chk("lit_lb", rf_wdata, 32'hFFFFFFF4);
        do_load(5'd7, 1'b1, 3'b100, 2'd2, 3, 32'h12F45678);
        @(negedge brq_clk);
        chk("lit_lbu", rf_wdata, 32'h000000F4);
        do_load(5'd8, 1'b1, 3'b001, 2'd2, 0, 32'h80017FFF);
        @(negedge brq_clk);
        chk("lit_lh", rf_wdata, 32'hFFFF8001);
        do_load(5'd8, 1'b1, 3'b101, 2'd2, 1, 32'h80017FFF);
        @(negedge brq_clk);
        chk("lit_lhu", rf_wdata, 32'h00008001);
        do_load(5'd8, 1'b1, 3'b010, 2'd2, c_LT - 1, 32'h80017FFF);
        @(negedge brq_clk);
        chk("lit_lw", rf_wdata, 32'h80017FFF);

        do_load(5'd9, 1'b1, 3'b010, 2'd0, c_LT, 32'h0);
        @(negedge brq_clk);
        chk("lit_to_err", {31'd0, load_err}, 32'd1);
        chk("lit_to_cnt", retire_cnt, 32'd7);
        do_idle(1'b1);
        do_idle(1'b1);

        // Reset in the second wait cycle together with a response.
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd3; mem_rd_we = 1'b1;
        mem_funct3 = 3'b010;
        tick();
        mem_valid = 1'b0;
        busy[cyc] = 1'b1;
        tick();
        busy[cyc]   = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        do_reset();
        dmem_rvalid = 1'b0;
        @(negedge brq_clk);
        chk("lit_rl_we", {31'd0, rf_we}, 32'd0);
        chk("lit_rl_wdata", rf_wdata, 32'd0);
        chk("lit_rl_ready", {31'd0, mem_ready}, 32'd1);

        for (int i = 0; i < 4; i++) do_alu(5'(i + 1), 1'b1, 32'hA0 + 32'(i));

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: do_idle(1'($urandom));
                1: do_alu(($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                          1'($urandom_range(0, 3) != 0), $urandom);
                default: begin
                    d = ($urandom_range(0, 4) == 0) ? c_LT : $urandom_range(0, c_LT - 1);
                    do_load(5'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom),
                            2'($urandom), d, $urandom);
                end
            endcase
        end
        do_idle(1'b0);
        do_idle(1'b0);
        @(negedge brq_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the BURAQ RV32I core, directly upstream of the register file.
- Accepts completed instructions from the memory stage. Waits for the data-memory response on loads, then byte/halfword-aligns and sign/zero-extends the loaded data.
- Drives a single-cycle write pulse into the register-file write port and counts retired instructions.
- Loads use a bounded wait: a load that gets no response within the timeout raises an error pulse.

Parameters:
- DataWidth, 32, datapath and register width.
- AddrRegWidth, 5, register address width.
- LoadTimeout, 16, maximum number of LOAD_WAIT cycles before the load is abandoned (must be ≥ 2).

Ports:
- brq_clk  in  1  clock; all state updates on posedge.
- brq_rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  memory stage presents an instruction.
- mem_ready  out  1  wb_stage can accept; equals 1 only in IDLE.
- mem_rd  in  AddrRegWidth  destination register.
- mem_rd_we  in  1  instruction writes rd.
- mem_is_load  in  1  instruction is a load.
- mem_funct3  in  3  load type.
- mem_addr_lsb  in  2  byte offset of the load address.
- mem_result  in  DataWidth  ALU/CSR/link result for non-loads.
- dmem_rvalid  in  1  data-memory read response valid.
- dmem_rdata  in  DataWidth  raw 32-bit word read from memory.
- rf_we  out  1  register-file write enable (one-cycle pulse).
- rf_waddr  out  AddrRegWidth  register-file write address.
- rf_wdata  out  DataWidth  register-file write data.
- load_err  out  1  one-cycle pulse on load timeout.
- retire_cnt  out  32  count of retired instructions; wraps.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - rf_we, rf_waddr, rf_wdata, load_err, retire_cnt and the timeout counter all go to 0.
  - mem_ready is 1 in the first cycle after reset.
- States: IDLE and LOAD_WAIT. mem_ready is 1 in IDLE and 0 in LOAD_WAIT.
- Handshake: an instruction is accepted on a cycle where mem_valid=1 and mem_ready=1. Upstream holds its inputs stable while mem_ready=0.
- Non-load accepted in IDLE:
  - On the next edge: rf_we = mem_rd_we & (mem_rd != 0), rf_waddr = mem_rd, rf_wdata = mem_result, and retire_cnt increments.
  - Latency is 1 cycle. Back-to-back non-loads sustain one per cycle.
  - Writes to x0 are suppressed here (rf_we=0) but still retire.
- Load accepted in IDLE:
  - Capture rd, rd_we, funct3 and lsb; clear the timeout counter; go to LOAD_WAIT.
- In LOAD_WAIT with dmem_rvalid=1:
  - On the next edge, rf_we = rd_we & (rd != 0) and rf_wdata is the extended data (below).
  - retire_cnt increments and the state returns to IDLE.
  - Latency from rvalid to rf_we is 1 cycle. The next instruction is accepted no earlier than 1 cycle after rvalid.
- Load extension; byte = dmem_rdata[8*lsb +: 8], half = dmem_rdata[16*lsb[1] +: 16]:
  - 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half.
  - 101 LHU: zero-extend half.
  - 010 LW: full word, lsb ignored.
  - 011, 110, 111: treated as LW.
  - Misalignment is checked upstream and is not re-checked here.
- Timeout:
  - The counter increments each LOAD_WAIT cycle without rvalid.
  - When it reaches LoadTimeout-1 with no rvalid in that cycle: on the next edge, load_err=1 for one cycle, no register write, no retire, and the state returns to IDLE.
  - If rvalid arrives in that same cycle, the response wins and there is no error.
- dmem_rvalid in IDLE is ignored, including a late response after a timeout.
- rf_we and load_err are single-cycle pulses. rf_waddr and rf_wdata hold their last values when rf_we=0.
- Reset asserted during LOAD_WAIT abandons the load with no write and no load_err. Reset has priority over every other event in the same cycle.
- retire_cnt wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset, then non-load: mem_rd=5, mem_rd_we=1, mem_result=0xDEADBEEF → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, retire_cnt=1.
- Non-load with mem_rd=0, mem_rd_we=1 → rf_we stays 0 and retire_cnt increments.
- LB with lsb=2, rdata=0x12F45678 after 3 wait cycles → mem_ready=0 while waiting, then rf_wdata=0xFFFFFFF4. LBU with the same inputs → 0x000000F4.
- LH with lsb=2, rdata=0x80017FFF → rf_wdata=0xFFFF8001. LHU → 0x00008001. LW → 0x80017FFF.
- Load with no rvalid → load_err pulses exactly LoadTimeout cycles after accept, with no rf_we and retire_cnt unchanged. A later rvalid in IDLE is ignored.
- Reset asserted in the 2nd LOAD_WAIT cycle with rvalid in the same cycle → no write, outputs zero, mem_ready=1 on the next cycle. Also: 4 back-to-back non-loads → 4 consecutive rf_we pulses.
